// File: rtl/txt_pkg.sv
// Shared constants and state type for the text-line fetch path.
// A text line is LINE_LEN characters addressed as {row, col} in the ROM bank.
package txt_pkg;

  localparam int LINE_LEN = 16;
  localparam int CHAR_W   = 7;
  localparam int XY_W     = 8;
  localparam int COL_W    = 4;
  localparam int ROW_W    = XY_W - COL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  function automatic logic [XY_W-1:0] make_xy(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and the rotating pointer;
// the pointer moves past the serviced requester when advance is pulsed.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  input  logic [IDX_W-1:0] adv_idx,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0]  ptr;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDX_W:0]    sum;

  // Rotate so the pointer position sits at bit 0; scan high-to-low so the
  // lowest rotated offset (closest to the pointer) is the last to win.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = NREQ'(req_dbl >> ptr);
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(NREQ)) begin
          sum = sum - (IDX_W+1)'(NREQ);
        end
        gnt_valid = 1'b1;
        gnt_idx   = sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (adv_idx == IDX_W'(NREQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= adv_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/txt_line_fetcher.sv
// Shares the 1-cycle-latency text ROM between draw requesters: fetches one
// 16-character line per grant into the line buffer, then pulses done.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting; arbiter grant latches requester id/row
//   ST_FETCH | issuing char_xy for col 0..15, writes trail by one cycle
//   ST_DRAIN | final write (col 15) while address holds
//   ST_DONE  | done pulse to granted requester, pointer advances
module txt_line_fetcher
  import txt_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*ID_W-1:0] req_id,
  input  logic [NREQ*4-1:0]    req_row,
  output logic [ID_W-1:0]      rom_sel,
  output logic [XY_W-1:0]      char_xy,
  input  logic [CHAR_W-1:0]    char_code,
  output logic                 wr_en,
  output logic [COL_W-1:0]     wr_addr,
  output logic [CHAR_W-1:0]    wr_data,
  output logic                 busy,
  output logic [NREQ-1:0]      done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  fetch_state_t     state;
  logic [COL_W-1:0] col;
  logic [IDX_W-1:0] gnt_q;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             advance;
  logic [ID_W-1:0]  sel_id;
  logic [ROW_W-1:0] sel_row;

  assign advance = (state == ST_DONE);

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (advance),
    .adv_idx   (gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_id  = '0;
    sel_row = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_id  = req_id[i*ID_W +: ID_W];
        sel_row = req_row[i*ROW_W +: ROW_W];
      end
    end
  end

  // ROM data arrives in the write cycle itself, so it passes straight through;
  // gating with wr_en keeps the bus at zero outside writes and under reset.
  assign wr_data = wr_en ? char_code : '0;

  // rom_sel and the row nibble of char_xy act as the latched job parameters
  // and are only reloaded on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      col     <= '0;
      gnt_q   <= '0;
      rom_sel <= '0;
      char_xy <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= '0;
          wr_en <= 1'b0;
          if (gnt_valid) begin
            gnt_q   <= gnt_idx;
            rom_sel <= sel_id;
            char_xy <= make_xy(sel_row, '0);
            col     <= '0;
            busy    <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          wr_en   <= 1'b1;
          wr_addr <= col;
          if (col == COL_W'(LINE_LEN - 1)) begin
            state <= ST_DRAIN;
          end else begin
            col     <= col + 1'b1;
            char_xy <= make_xy(char_xy[XY_W-1:COL_W], col + 1'b1);
          end
        end
        ST_DRAIN: begin
          wr_en <= 1'b0;
          done  <= NREQ'(1) << gnt_q;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          col   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_txt_line_fetcher.sv
// Self-checking bench for txt_line_fetcher: ROM model, passive job monitor,
// and a round-robin reference for grant order and line contents.
module tb_txt_line_fetcher;

  localparam int NREQ = 2;
  localparam int ID_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*ID_W-1:0] req_id;
  logic [NREQ*4-1:0]    req_row;
  logic [ID_W-1:0]      rom_sel;
  logic [7:0]           char_xy;
  logic [6:0]           char_code;
  logic                 wr_en;
  logic [3:0]           wr_addr;
  logic [6:0]           wr_data;
  logic                 busy;
  logic [NREQ-1:0]      done;

  always #5 clk = ~clk;

  txt_line_fetcher #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_id    (req_id),
    .req_row   (req_row),
    .rom_sel   (rom_sel),
    .char_xy   (char_xy),
    .char_code (char_code),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  // ROM content: for id 3 / row 2 this is col + 0x41.
  function automatic logic [6:0] rom_fn(int id, int row, int col);
    return 7'(65 + col + 16 * row + 5 * id - 47);
  endfunction

  function automatic int rr_pick(logic [NREQ-1:0] mask, int ptr);
    for (int i = 0; i < NREQ; i++) begin
      int k = (ptr + i) % NREQ;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  typedef struct {
    int              start;
    int              done_cyc;
    logic [NREQ-1:0] done_vec;
    logic [ID_W-1:0] sel;
    bit              sel_stable;
    logic [127:0]    xy;
    logic [63:0]     wa;
    logic [111:0]    wd;
    int              nwr;
    int              busy_cycles;
  } job_t;

  job_t jobs[$];
  job_t cur;
  bit   in_job;
  int   cyc;
  int   total_done;
  int   total_wr;
  int   n_checks;
  int   n_fail;
  logic [3:0] tid [NREQ];
  logic [3:0] trow[NREQ];

  initial begin
    char_code = '0;
    forever begin
      @(posedge clk);
      char_code <= rom_fn(int'(rom_sel), int'(char_xy[7:4]), int'(char_xy[3:0]));
    end
  end

  initial begin
    cyc = 0; in_job = 0; total_done = 0; total_wr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_job = 0;
      end else begin
        if (busy && !in_job) begin
          in_job = 1;
          cur = '{start: cyc, done_cyc: 0, done_vec: '0, sel: rom_sel, sel_stable: 1'b1,
                  xy: '0, wa: '0, wd: '0, nwr: 0, busy_cycles: 0};
        end
        if (in_job) begin
          if (cyc - cur.start < 16) cur.xy[(cyc - cur.start)*8 +: 8] = char_xy;
          if (rom_sel !== cur.sel) cur.sel_stable = 1'b0;
          if (busy) cur.busy_cycles++;
          if (wr_en) begin
            if (cur.nwr < 16) begin
              cur.wa[cur.nwr*4 +: 4] = wr_addr;
              cur.wd[cur.nwr*7 +: 7] = wr_data;
            end
            cur.nwr++;
          end
          if (done != '0) begin
            cur.done_cyc = cyc;
            cur.done_vec = done;
            jobs.push_back(cur);
            in_job = 0;
          end
        end
        if (done != '0) total_done++;
        if (wr_en) total_wr++;
      end
    end
  end

  task automatic set_ids();
    for (int i = 0; i < NREQ; i++) begin
      req_id[i*ID_W +: ID_W] = tid[i];
      req_row[i*4 +: 4]      = trow[i];
    end
  endtask

  task automatic randomize_ids();
    for (int i = 0; i < NREQ; i++) begin
      tid[i]  = 4'($urandom_range(0, 15));
      trow[i] = 4'($urandom_range(0, 15));
    end
    set_ids();
  endtask

  // One cycle; a requester that sees its done drops req unless told to persist.
  task automatic step(input logic [NREQ-1:0] persist);
    @(negedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (done[i] && !persist[i]) req[i] = 1'b0;
    end
  endtask

  task automatic wait_jobs(input int n, input logic [NREQ-1:0] persist, output bit ok);
    int budget = 0;
    while (jobs.size() < n && budget < 40 * n + 40) begin
      step(persist);
      budget++;
    end
    ok = (jobs.size() >= n);
  endtask

  task automatic wait_col(input logic [3:0] c, output bit ok);
    int budget = 0;
    ok = 0;
    while (!ok && budget < 60) begin
      step('0);
      budget++;
      if (busy && !wr_en && char_xy[3:0] == c) ok = 1;
      else if (busy && wr_en && char_xy[3:0] == c && c != 4'd15) ok = 1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    jobs.delete();
    total_done = 0;
    total_wr   = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_id = '0; req_row = '0;
    #1;
    n_checks++; if (rom_sel !== '0) begin n_fail++; $display("FAIL reset_rom_sel: got %h want 0", rom_sel); end
    n_checks++; if (char_xy !== '0) begin n_fail++; $display("FAIL reset_char_xy: got %h want 0", char_xy); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_checks++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    apply_reset();
  endtask

  task automatic test_single();
    bit ok;
    int c0, bad_xy, bad_wa, bad_wd;
    apply_reset();
    tid[0] = 4'd3; trow[0] = 4'd2; tid[1] = 4'd9; trow[1] = 4'd7;
    set_ids();
    req = 2'b01;
    c0 = cyc;
    wait_jobs(1, '0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d jobs want 1", jobs.size()); return; end
    n_checks++; if (jobs[0].start !== c0 + 1) begin n_fail++; $display("FAIL single_start: got cycle %0d want %0d", jobs[0].start, c0 + 1); end
    n_checks++; if (jobs[0].done_vec !== 2'b01) begin n_fail++; $display("FAIL single_done_vec: got %b want 01", jobs[0].done_vec); end
    n_checks++; if (jobs[0].done_cyc - jobs[0].start !== 17) begin n_fail++; $display("FAIL single_done_time: got +%0d want +17", jobs[0].done_cyc - jobs[0].start); end
    n_checks++; if (jobs[0].busy_cycles !== 18) begin n_fail++; $display("FAIL single_busy_len: got %0d want 18", jobs[0].busy_cycles); end
    n_checks++; if (jobs[0].sel !== 4'd3) begin n_fail++; $display("FAIL single_rom_sel: got %h want 3", jobs[0].sel); end
    n_checks++; if (jobs[0].nwr !== 16) begin n_fail++; $display("FAIL single_nwr: got %0d want 16", jobs[0].nwr); end
    bad_xy = 0; bad_wa = 0; bad_wd = 0;
    for (int k = 0; k < 16; k++) begin
      if (jobs[0].xy[k*8 +: 8] !== 8'(32 + k)) bad_xy++;
      if (jobs[0].wa[k*4 +: 4] !== 4'(k)) bad_wa++;
      if (jobs[0].wd[k*7 +: 7] !== 7'(65 + k)) bad_wd++;
    end
    n_checks++; if (bad_xy !== 0) begin n_fail++; $display("FAIL single_char_xy: got %h want 2f2e..2120", jobs[0].xy); end
    n_checks++; if (bad_wa !== 0) begin n_fail++; $display("FAIL single_wr_addr: got %h want fedc..3210", jobs[0].wa); end
    n_checks++; if (bad_wd !== 0) begin n_fail++; $display("FAIL single_wr_data: %0d of 16 wrong, got %h", bad_wd, jobs[0].wd); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    apply_reset();
    randomize_ids();
    req = 2'b11;
    wait_jobs(2, '0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout: got %0d jobs want 2", jobs.size()); return; end
    n_checks++; if (jobs[0].done_vec !== 2'b01) begin n_fail++; $display("FAIL b2b_first: got %b want 01", jobs[0].done_vec); end
    n_checks++; if (jobs[1].done_vec !== 2'b10) begin n_fail++; $display("FAIL b2b_second: got %b want 10", jobs[1].done_vec); end
    n_checks++; if (jobs[1].start - jobs[0].done_cyc !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d want 2", jobs[1].start - jobs[0].done_cyc); end
    n_checks++; if (jobs[1].sel !== tid[1]) begin n_fail++; $display("FAIL b2b_sel1: got %h want %h", jobs[1].sel, tid[1]); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (jobs[1].xy[k*8 +: 8] !== {trow[1], 4'(k)}) bad++;
      if (jobs[1].wd[k*7 +: 7] !== rom_fn(int'(tid[1]), int'(trow[1]), k)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_line1: %0d wrong, got xy %h data %h", bad, jobs[1].xy, jobs[1].wd); end
  endtask

  task automatic test_alternate();
    bit ok;
    int ptr, g;
    apply_reset();
    randomize_ids();
    req = 2'b11;
    wait_jobs(4, 2'b11, ok);
    req = '0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL alt_timeout: got %0d jobs want 4", jobs.size()); return; end
    ptr = 0;
    for (int j = 0; j < 4; j++) begin
      g = rr_pick(2'b11, ptr);
      ptr = (g + 1) % NREQ;
      n_checks++; if (jobs[j].done_vec !== NREQ'(1 << g)) begin n_fail++; $display("FAIL alt_order_%0d: got %b want %b", j, jobs[j].done_vec, NREQ'(1 << g)); end
      n_checks++; if (jobs[j].sel !== tid[g]) begin n_fail++; $display("FAIL alt_sel_%0d: got %h want %h", j, jobs[j].sel, tid[g]); end
    end
    repeat (25) step('0);
  endtask

  task automatic test_drop();
    bit ok;
    int bad;
    apply_reset();
    randomize_ids();
    req = 2'b10;
    wait_col(4'd5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_col5_timeout: col 5 not seen, got xy %h", char_xy); end
    req[1] = 1'b0;
    wait_jobs(1, '0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_timeout: got %0d jobs want 1", jobs.size()); return; end
    n_checks++; if (jobs[0].done_vec !== 2'b10) begin n_fail++; $display("FAIL drop_done: got %b want 10", jobs[0].done_vec); end
    n_checks++; if (jobs[0].nwr !== 16) begin n_fail++; $display("FAIL drop_nwr: got %0d want 16", jobs[0].nwr); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (jobs[0].wa[k*4 +: 4] !== 4'(k)) bad++;
      if (jobs[0].wd[k*7 +: 7] !== rom_fn(int'(tid[1]), int'(trow[1]), k)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL drop_line: %0d wrong, got addr %h data %h", bad, jobs[0].wa, jobs[0].wd); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0, d0;
    apply_reset();
    randomize_ids();
    req = 2'b01;
    wait_jobs(1, '0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_pre_timeout: got %0d jobs want 1", jobs.size()); return; end
    req = 2'b10;
    wait_col(4'd8, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_col8_timeout: col 8 not seen, got xy %h", char_xy); end
    rst = 1'b1;
    #1;
    n_checks++; if ({rom_sel, char_xy, wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got sel %h xy %h we %b wa %h wd %h busy %b done %b want all 0",
               rom_sel, char_xy, wr_en, wr_addr, wr_data, busy, done);
    end
    n0 = jobs.size();
    d0 = total_done;
    req = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (25) step('0);
    n_checks++; if (total_done !== d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d done pulses want %0d", total_done, d0); end
    randomize_ids();
    req = 2'b11;
    wait_jobs(n0 + 2, '0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_post_timeout: got %0d jobs want %0d", jobs.size(), n0 + 2); return; end
    n_checks++; if (jobs[n0].done_vec !== 2'b01) begin n_fail++; $display("FAIL rmid_ptr_reset: got %b want 01", jobs[n0].done_vec); end
    n_checks++; if (jobs[n0].xy[7:0] !== {trow[0], 4'h0}) begin n_fail++; $display("FAIL rmid_col0: got %h want %h", jobs[n0].xy[7:0], {trow[0], 4'h0}); end
    n_checks++; if (jobs[n0].nwr !== 16) begin n_fail++; $display("FAIL rmid_nwr: got %0d want 16", jobs[n0].nwr); end
  endtask

  task automatic test_change_mid();
    bit ok;
    int bad, budget;
    logic [3:0] id0, row0;
    apply_reset();
    randomize_ids();
    id0 = tid[0]; row0 = trow[0];
    req = 2'b01;
    budget = 0;
    while (!busy && budget < 10) begin step('0); budget++; end
    step('0);
    tid[0]  = id0 ^ 4'($urandom_range(1, 15));
    trow[0] = row0 ^ 4'($urandom_range(1, 15));
    set_ids();
    wait_jobs(1, '0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL chg_timeout: got %0d jobs want 1", jobs.size()); return; end
    n_checks++; if (jobs[0].sel !== id0 || !jobs[0].sel_stable) begin n_fail++; $display("FAIL chg_sel: got %h stable %b want %h stable 1", jobs[0].sel, jobs[0].sel_stable, id0); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (jobs[0].xy[k*8 +: 8] !== {row0, 4'(k)}) bad++;
      if (jobs[0].wd[k*7 +: 7] !== rom_fn(int'(id0), int'(row0), k)) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL chg_line: %0d wrong, got xy %h data %h", bad, jobs[0].xy, jobs[0].wd); end
  endtask

  task automatic test_random();
    bit ok;
    int ptr, g, n0, bad;
    int exp_q[$];
    logic [NREQ-1:0] mask, pend;
    apply_reset();
    ptr = 0;
    for (int r = 0; r < 6; r++) begin
      randomize_ids();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      pend = mask;
      exp_q.delete();
      while (pend != '0) begin
        g = rr_pick(pend, ptr);
        exp_q.push_back(g);
        pend[g] = 1'b0;
        ptr = (g + 1) % NREQ;
      end
      n0 = jobs.size();
      req = mask;
      wait_jobs(n0 + exp_q.size(), '0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout_%0d: got %0d jobs want %0d", r, jobs.size(), n0 + exp_q.size()); return; end
      foreach (exp_q[j]) begin
        g = exp_q[j];
        n_checks++; if (jobs[n0+j].done_vec !== NREQ'(1 << g)) begin n_fail++; $display("FAIL rand_order_%0d_%0d: got %b want %b", r, j, jobs[n0+j].done_vec, NREQ'(1 << g)); end
        bad = 0;
        if (jobs[n0+j].sel !== tid[g] || jobs[n0+j].nwr !== 16) bad++;
        for (int k = 0; k < 16; k++) begin
          if (jobs[n0+j].xy[k*8 +: 8] !== {trow[g], 4'(k)}) bad++;
          if (jobs[n0+j].wd[k*7 +: 7] !== rom_fn(int'(tid[g]), int'(trow[g]), k)) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_line_%0d_%0d: %0d wrong, sel %h nwr %0d", r, j, bad, jobs[n0+j].sel, jobs[n0+j].nwr); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_alternate();
    test_drop();
    test_reset_mid();
    test_change_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
